// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC sequencer: FSM states, default
// reset vector and fetch increment, and the target alignment helper.
package npc_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    PEND = 2'd2
  } npc_state_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEF    = 32'd4;

  // Redirect targets are word addresses; the low two bits are discarded.
  function automatic logic [31:0] align_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/npc_redirect_buf.sv
// Pending-redirect buffer: holds one redirect target captured while fetch
// is stalled, plus a flag saying the target is live.
module npc_redirect_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] q_reg;
  logic         valid_reg;

  // Clear wins over load so a release never re-captures in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg     <= '0;
      valid_reg <= 1'b0;
    end else if (clear) begin
      q_reg     <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      q_reg     <= d;
      valid_reg <= 1'b1;
    end
  end

  assign q     = q_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/npc_sequencer.sv
// Next-PC sequencer: picks sequential fetch, branch redirect or a redirect
// buffered across a stall. Every output comes straight from a register.
module npc_sequencer
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] PC_INC    = PC_INC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] npc,
  output logic        npc_valid,
  output logic        flush,
  output logic        redirect_pend,
  output logic        align_err
);

  npc_state_e  state_reg;
  logic [31:0] npc_reg;
  logic        npc_valid_reg;
  logic        flush_reg;
  logic        align_err_reg;

  logic        buf_load;
  logic        buf_clear;
  logic [31:0] buf_q;
  logic        buf_valid;
  logic [31:0] target_aligned;
  logic        target_misaligned;

  assign target_aligned    = align_addr(br_target);
  assign target_misaligned = |br_target[1:0];

  // Buffer control: capture on stalled redirect, drop on release from PEND.
  always_comb begin
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if ((state_reg != PEND) && stall && br_taken) buf_load = 1'b1;
    if ((state_reg == PEND) && !stall)            buf_clear = 1'b1;
  end

  npc_redirect_buf #(.W(32)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .d     (target_aligned),
    .q     (buf_q),
    .valid (buf_valid)
  );

  // Sequencer FSM with registered npc and single-cycle flush/align pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      npc_reg       <= RESET_VEC;
      npc_valid_reg <= 1'b0;
      flush_reg     <= 1'b0;
      align_err_reg <= 1'b0;
    end else begin
      npc_valid_reg <= 1'b1;
      flush_reg     <= 1'b0;
      align_err_reg <= 1'b0;
      unique case (state_reg)
        RUN, HOLD: begin
          if (!stall) begin
            state_reg <= RUN;
            if (br_taken) begin
              npc_reg       <= target_aligned;
              flush_reg     <= 1'b1;
              align_err_reg <= target_misaligned;
            end else begin
              npc_reg <= pc + PC_INC;
            end
          end else if (br_taken) begin
            // Redirect arrives while stalled: park it, no flush yet.
            state_reg     <= PEND;
            align_err_reg <= target_misaligned;
          end else begin
            state_reg <= HOLD;
          end
        end
        PEND: begin
          // Later redirects are ignored here; the older one wins.
          if (!stall) begin
            state_reg <= RUN;
            npc_reg   <= buf_q;
            flush_reg <= 1'b1;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign npc           = npc_reg;
  assign npc_valid     = npc_valid_reg;
  assign flush         = flush_reg;
  assign redirect_pend = buf_valid;
  assign align_err     = align_err_reg;

endmodule

// File: tb/tb_npc_sequencer.sv
// Directed table-driven bench for npc_sequencer plus hand-written
// sequences for free-running feedback and reset while a redirect is pending.
module tb_npc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] npc;
  logic        npc_valid;
  logic        flush;
  logic        redirect_pend;
  logic        align_err;

  int n_cmp = 0;
  int n_err = 0;

  npc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .npc          (npc),
    .npc_valid    (npc_valid),
    .flush        (flush),
    .redirect_pend(redirect_pend),
    .align_err    (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        s;
    logic        b;
    logic [31:0] tgt;
    logic [31:0] p;
    logic [31:0] e_npc;
    logic        e_v;
    logic        e_f;
    logic        e_p;
    logic        e_a;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the rising edge.
  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [31:0] t, input logic [31:0] p);
    rst = r; stall = s; br_taken = b; br_target = t; pc = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_npc, input logic e_v,
                         input logic e_f, input logic e_p, input logic e_a);
    chk({tag, " npc"}, npc, e_npc);
    chk({tag, " npc_valid"}, {31'd0, npc_valid}, {31'd0, e_v});
    chk({tag, " flush"}, {31'd0, flush}, {31'd0, e_f});
    chk({tag, " redirect_pend"}, {31'd0, redirect_pend}, {31'd0, e_p});
    chk({tag, " align_err"}, {31'd0, align_err}, {31'd0, e_a});
    $display("%s: rst=%b stall=%b br=%b tgt=%h pc=%h -> npc=%h v=%b f=%b p=%b a=%b",
             tag, rst, stall, br_taken, br_target, pc, npc, npc_valid, flush,
             redirect_pend, align_err);
  endtask

  initial begin
    logic [31:0] exp_npc;

    //           r     s     b     tgt            pc             npc            v     f     p     a
    vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h4,         1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h8,         1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'hC,         1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 32'h200,       32'h10,        32'h200,       1'b1, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         32'h200,       32'h204,       1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 32'h102,       32'h0,         32'h100,       1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         32'h100,       32'h104,       1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 32'h0,         32'h104,       32'h104,       1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 32'h300,       32'h104,       32'h104,       1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 32'h400,       32'h104,       32'h104,       1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 32'h0,         32'h104,       32'h104,       1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 32'h500,       32'h104,       32'h300,       1'b1, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         32'h300,       32'h304,       1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 32'h0,         32'h304,       32'h304,       1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 32'h603,       32'h304,       32'h600,       1'b1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{1'b0, 1'b1, 1'b1, 32'h701,       32'h600,       32'h600,       1'b1, 1'b0, 1'b1, 1'b1});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         32'h600,       32'h700,       1'b1, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 32'h0,         32'h700,       32'h700,       1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,         32'h700,       32'h704,       1'b1, 1'b0, 1'b0, 1'b0});

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].s, vq[i].b, vq[i].tgt, vq[i].p);
      chk_all($sformatf("row%0d", i), vq[i].e_npc, vq[i].e_v, vq[i].e_f, vq[i].e_p, vq[i].e_a);
    end

    // Free-run with pc fed back from npc: sequential +4 steps.
    exp_npc = 32'h704;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, npc);
      exp_npc = exp_npc + 32'd4;
      chk_all($sformatf("free%0d", k), exp_npc, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Enter PEND, then reset while stalled with another redirect requested.
    drive(1'b0, 1'b1, 1'b1, 32'h800, npc);
    chk_all("pend0", 32'h714, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h900, npc);
    chk_all("pend1", 32'h714, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'hA00, npc);
    chk_all("rstpend", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // After release: plain sequential fetch from the reset vector, no flush.
    exp_npc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, npc);
      exp_npc = exp_npc + 32'd4;
      chk_all($sformatf("postrst%0d", k), exp_npc, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // A stall/release must not resurrect the discarded 0x800 target.
    drive(1'b0, 1'b1, 1'b0, 32'h0, npc);
    chk_all("hold", 32'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, npc);
    chk_all("release", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/npc_sequencer.md
NPC_SEQUENCER -- requirements
Module: npc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 Parameter PC_INC, default 32'd4, meaning the sequential fetch increment in bytes.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1, meaning the single clock (all state updates on the rising edge).
REQ-005 Port rst, input, 1, meaning the synchronous active-high reset.
REQ-006 Port pc, input, 32, meaning the current PC fed back from the PC register.
REQ-007 Port stall, input, 1, meaning the hazard-unit request to hold fetch.
REQ-008 Port br_taken, input, 1, meaning the redirect request from the branch/jump resolve stage.
REQ-009 Port br_target, input, 32, meaning the redirect address, valid only when br_taken=1.
REQ-010 Port npc, output, 32, meaning the registered next-PC driven to the PC register.
REQ-011 Port npc_valid, output, 1, meaning that npc holds a fetch address to be consumed.
REQ-012 Port flush, output, 1, meaning a one-cycle pulse to squash wrong-path IF/ID contents.
REQ-013 Port redirect_pend, output, 1, meaning a redirect is buffered while stalled.
REQ-014 Port align_err, output, 1, meaning a one-cycle pulse when an accepted br_target has bits [1:0] not equal to 00.

Function
REQ-015 The FSM SHALL have the states RUN, HOLD and PEND; all outputs SHALL be registered with 1-cycle latency.
REQ-016 RUN with stall=0 and br_taken=0 SHALL set npc to pc+PC_INC modulo 2^32 (32'hFFFF_FFFC goes to 32'h0000_0000) and stay in RUN.
REQ-017 RUN with stall=0 and br_taken=1 SHALL set npc to {br_target[31:2],2'b00}, pulse flush for one cycle and stay in RUN.
REQ-018 RUN or HOLD with stall=1 and br_taken=0 SHALL hold npc and go to or remain in HOLD.
REQ-019 HOLD with stall=0 and br_taken=0 SHALL set npc to pc+PC_INC and go to RUN.
REQ-020 HOLD with stall=0 and br_taken=1 SHALL follow REQ-017 and go to RUN.
REQ-021 RUN or HOLD with stall=1 and br_taken=1 SHALL hold npc, capture the aligned target into the pending buffer, set redirect_pend=1, not pulse flush, and go to PEND.
REQ-022 In PEND, a further br_taken SHALL be ignored, so the first-captured (older) redirect wins.
REQ-023 PEND with stall=1 SHALL hold npc and the buffer.
REQ-024 PEND with stall=0 SHALL set npc to the buffered target, pulse flush, clear redirect_pend and go to RUN.
REQ-025 align_err SHALL pulse in the cycle after any br_taken is accepted (REQ-017, REQ-020, REQ-021) with br_target[1:0]!=0; the redirect SHALL proceed with the low bits forced to 0.
REQ-026 flush and align_err SHALL never be high for more than one consecutive cycle per redirect.

Reset
REQ-027 A reset SHALL set npc=RESET_VEC, npc_valid=0, flush=0, redirect_pend=0, align_err=0, state=RUN and clear the pending buffer.
REQ-028 npc_valid SHALL rise in the first cycle after rst deasserts and stay at 1 until the next reset.
REQ-029 A reset SHALL take priority over stall and br_taken in any state, including PEND, and SHALL discard the buffered target.

Structure
REQ-030 The shared package npc_pkg SHALL hold the state enum {RUN,HOLD,PEND}, RESET_VEC_DEF and PC_INC_DEF.
REQ-031 The pending target register and its valid bit SHALL be a single sub-module, npc_redirect_buf (ports: clk, rst, load, clear, d, q, valid).

Verification
REQ-032 Reset then free-run with pc fed back from npc -> npc sequence 0x0, 0x4, 0x8, 0xC; npc_valid=1 from cycle 1; flush=0.
REQ-033 With pc=0x10, br_taken=1, br_target=0x200, stall=0 -> next npc=0x200, flush=1 for exactly one cycle.
REQ-034 With stall=1 and br_taken=1, target=0x300, then br_taken=1, target=0x400 while stalled, then stall=0 -> npc held; redirect_pend=1; on release npc=0x300 and flush=1; 0x400 is dropped.
REQ-035 With pc=0xFFFF_FFFC, no stall -> npc=0x0000_0000 (wrap).
REQ-036 With br_target=0x0000_0102 accepted -> npc=0x0000_0100, align_err=1 for one cycle.
REQ-037 rst=1 while in PEND -> next cycle npc=RESET_VEC, redirect_pend=0, state=RUN; after release, sequential fetch from RESET_VEC with no flush.
